pwm_deadtime: RTL and testbench

PWM_DEADTIME -- requirements
Module: pwm_deadtime

---
 rtl/pwm_deadtime_pkg.sv | 27 ++
 rtl/pwm_deadtime_carrier.sv | 114 +++++++++++
 rtl/pwm_deadtime.sv | 123 ++++++++++++
 tb/tb_pwm_deadtime.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_deadtime_pkg.sv
// Shared types and defaults for the dead-time PWM generator: gate FSM
// state encoding, parameter defaults and the dead-time entry helper.
package pwm_deadtime_pkg;

   typedef enum logic [2:0] {
      ST_OFF   = 3'd0,
      ST_DT_HI = 3'd1,
      ST_HI    = 3'd2,
      ST_DT_LO = 3'd3,
      ST_LO    = 3'd4
   } pwm_state_e;

   localparam int unsigned DEF_CNT_W      = 16;
   localparam int unsigned DEF_DT_W       = 8;
   localparam int unsigned DEF_RST_PERIOD = 100;
   localparam int unsigned DEF_RST_DT     = 4;

   // State to enter when heading for one gate; a zero dead-time goes
   // straight to the conducting state.
   function automatic pwm_state_e dt_entry(input logic toward_hi, input logic dt_zero);
      if (toward_hi) begin
         return dt_zero ? ST_HI : ST_DT_HI;
      end
      return dt_zero ? ST_LO : ST_DT_LO;
   endfunction

endpackage

// File: rtl/pwm_deadtime_carrier.sv
// PWM carrier: period counter, single-entry config shadow, active config
// registers, raw duty compare and the cycle-start pulse.
module pwm_carrier
   import pwm_deadtime_pkg::*;
#(
   parameter int unsigned CNT_W      = DEF_CNT_W,
   parameter int unsigned DT_W       = DEF_DT_W,
   parameter int unsigned RST_PERIOD = DEF_RST_PERIOD,
   parameter int unsigned RST_DT     = DEF_RST_DT
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_i,
   input  logic             cfg_valid_i,
   output logic             cfg_ready_o,
   input  logic [CNT_W-1:0] cfg_period_i,
   input  logic [CNT_W-1:0] cfg_duty_i,
   input  logic [DT_W-1:0]  cfg_dt_i,
   output logic             cfg_err_o,
   output logic             raw_o,
   output logic [DT_W-1:0]  dt_o,
   output logic             cyc_start_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] duty_q, duty_d;
   logic [DT_W-1:0]  dt_q, dt_d;
   logic [CNT_W-1:0] sh_period_q, sh_duty_q;
   logic [DT_W-1:0]  sh_dt_q;
   logic             sh_full_q, sh_full_d;
   logic             cfg_err_q, cfg_err_d;
   logic             cyc_start_q, cyc_start_d;
   logic             wrap, offer, accept, load_active;

   // Next-state logic for counter, shadow occupancy and active config.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // leaves one unassigned and no latch is inferred.
      cnt_d       = cnt_q;
      period_d    = period_q;
      duty_d      = duty_q;
      dt_d        = dt_q;
      sh_full_d   = sh_full_q;

      // period_q is never zero, so the subtraction cannot underflow.
      wrap        = en_i && (cnt_q >= period_q - CNT_W'(1));
      offer       = cfg_valid_i && !sh_full_q;
      accept      = offer && (cfg_period_i != '0);
      load_active = sh_full_q && (wrap || !en_i);

      cyc_start_d = wrap;
      cfg_err_d   = offer && (cfg_period_i == '0);

      if (!en_i || wrap) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      // accept needs an empty shadow and load_active a full one, so the
      // two never coincide.
      if (load_active) begin
         period_d  = sh_period_q;
         duty_d    = sh_duty_q;
         dt_d      = sh_dt_q;
         sh_full_d = 1'b0;
      end
      if (accept) begin
         sh_full_d = 1'b1;
      end
   end

   // Control and active-config registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (!rst_n) begin
         cnt_q       <= '0;
         period_q    <= CNT_W'(RST_PERIOD);
         duty_q      <= '0;
         dt_q        <= DT_W'(RST_DT);
         sh_full_q   <= 1'b0;
         cfg_err_q   <= 1'b0;
         cyc_start_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         period_q    <= period_d;
         duty_q      <= duty_d;
         dt_q        <= dt_d;
         sh_full_q   <= sh_full_d;
         cfg_err_q   <= cfg_err_d;
         cyc_start_q <= cyc_start_d;
      end
   end

   // Shadow payload capture on an accepted offer.
   always_ff @(posedge clk) begin
      // NOTE: payload is deliberately not reset; it is only ever read while
      // sh_full_q is set, and sh_full_q itself is reset.
      if (accept) begin
         sh_period_q <= cfg_period_i;
         sh_duty_q   <= cfg_duty_i;
         sh_dt_q     <= cfg_dt_i;
      end
   end

   assign cfg_ready_o = !sh_full_q;
   assign cfg_err_o   = cfg_err_q;
   assign cyc_start_o = cyc_start_q;
   assign raw_o       = (cnt_q < duty_q);
   assign dt_o        = dt_q;

endmodule

// File: rtl/pwm_deadtime.sv
// Complementary gate driver with dead-time insertion. The carrier supplies
// the raw PWM level; this FSM turns it into non-overlapping sw1/sw2 gates.
module pwm_deadtime
   import pwm_deadtime_pkg::*;
#(
   parameter int unsigned CNT_W      = DEF_CNT_W,
   parameter int unsigned DT_W       = DEF_DT_W,
   parameter int unsigned RST_PERIOD = DEF_RST_PERIOD,
   parameter int unsigned RST_DT     = DEF_RST_DT
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CNT_W-1:0] cfg_period,
   input  logic [CNT_W-1:0] cfg_duty,
   input  logic [DT_W-1:0]  cfg_dt,
   output logic             cfg_err,
   output logic             sw1,
   output logic             sw2,
   output logic             cyc_start
);

   logic            raw;
   logic [DT_W-1:0] dt_act;
   logic            dt_zero;

   pwm_state_e      state_q, state_d;
   logic [DT_W-1:0] dt_cnt_q, dt_cnt_d;
   logic            sw1_q, sw2_q;

   pwm_carrier #(
      .CNT_W      (CNT_W),
      .DT_W       (DT_W),
      .RST_PERIOD (RST_PERIOD),
      .RST_DT     (RST_DT)
   ) u_carrier (
      .clk          (clk),
      .rst_n        (rst_n),
      .en_i         (en),
      .cfg_valid_i  (cfg_valid),
      .cfg_ready_o  (cfg_ready),
      .cfg_period_i (cfg_period),
      .cfg_duty_i   (cfg_duty),
      .cfg_dt_i     (cfg_dt),
      .cfg_err_o    (cfg_err),
      .raw_o        (raw),
      .dt_o         (dt_act),
      .cyc_start_o  (cyc_start)
   );

   assign dt_zero = (dt_act == '0);

   // Gate FSM: dead-time counts down dt cycles between gates; a raw edge
   // back toward the gate just released returns to it without dead-time.
   always_comb begin
      state_d  = state_q;
      dt_cnt_d = dt_cnt_q;
      if (!en) begin
         state_d  = ST_OFF;
         dt_cnt_d = '0;
      end else begin
         case (state_q)
            ST_OFF: begin
               state_d  = dt_entry(raw, dt_zero);
               dt_cnt_d = dt_act;
            end
            ST_LO: begin
               if (raw) begin
                  state_d  = dt_entry(1'b1, dt_zero);
                  dt_cnt_d = dt_act;
               end
            end
            ST_HI: begin
               if (!raw) begin
                  state_d  = dt_entry(1'b0, dt_zero);
                  dt_cnt_d = dt_act;
               end
            end
            ST_DT_HI: begin
               if (!raw) begin
                  state_d = ST_LO;
               end else if (dt_cnt_q <= DT_W'(1)) begin
                  state_d = ST_HI;
               end else begin
                  dt_cnt_d = dt_cnt_q - DT_W'(1);
               end
            end
            ST_DT_LO: begin
               if (raw) begin
                  state_d = ST_HI;
               end else if (dt_cnt_q <= DT_W'(1)) begin
                  state_d = ST_LO;
               end else begin
                  dt_cnt_d = dt_cnt_q - DT_W'(1);
               end
            end
            default: state_d = ST_OFF;
         endcase
      end
   end

   // FSM and gate registers; gates decode the next state so they stay
   // aligned with state_q and come straight from flops.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_OFF;
         dt_cnt_q <= '0;
         sw1_q    <= 1'b0;
         sw2_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         dt_cnt_q <= dt_cnt_d;
         sw1_q    <= (state_d == ST_HI);
         sw2_q    <= (state_d == ST_LO);
      end
   end

   assign sw1 = sw1_q;
   assign sw2 = sw2_q;

endmodule

// File: tb/tb_pwm_deadtime.sv
// Bench for pwm_deadtime. The driver pushes the expected sw1/sw2 pattern of
// each full carrier period (cnt=0..period-1, bit i = cycle with cnt=i) and
// each expected cfg_err pulse; the monitor pops and compares whenever the
// DUT presents a cyc_start or cfg_err.
module tb_pwm_deadtime;
   import pwm_deadtime_pkg::*;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          len;
   } win_t;

   logic        clk        = 1'b0;
   logic        rst_n      = 1'b0;
   logic        en         = 1'b0;
   logic        cfg_valid  = 1'b0;
   logic        cfg_ready;
   logic [15:0] cfg_period = '0;
   logic [15:0] cfg_duty   = '0;
   logic [7:0]  cfg_dt     = '0;
   logic        cfg_err;
   logic        sw1;
   logic        sw2;
   logic        cyc_start;

   int   total = 0;
   int   bad   = 0;
   win_t win_q[$];
   bit   err_q[$];
   int   ovl_cycles = 0;

   pwm_deadtime dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_period (cfg_period),
      .cfg_duty   (cfg_duty),
      .cfg_dt     (cfg_dt),
      .cfg_err    (cfg_err),
      .sw1        (sw1),
      .sw2        (sw2),
      .cyc_start  (cyc_start)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic void push_win(input logic [31:0] hi, input logic [31:0] lo,
                                    input int len, input int n);
      win_t w;
      w.hi  = hi;
      w.lo  = lo;
      w.len = len;
      for (int i = 0; i < n; i++) win_q.push_back(w);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cs(input int n);
      int c;
      for (int k = 0; k < n; k++) begin
         c = 0;
         do begin
            @(negedge clk);
            c++;
         end while (!cyc_start && c < 200);
         if (!cyc_start) begin
            total++;
            bad++;
            $display("FAIL wait_cs: no cyc_start within %0d cycles", c);
         end
      end
   endtask

   task automatic send_cfg(input logic [15:0] p, input logic [15:0] d, input logic [7:0] t);
      int c;
      c          = 0;
      cfg_period = p;
      cfg_duty   = d;
      cfg_dt     = t;
      cfg_valid  = 1'b1;
      while (!cfg_ready && c < 50) begin
         tick();
         c++;
      end
      if (!cfg_ready) begin
         total++;
         bad++;
         $display("FAIL send_cfg: cfg_ready stuck low for %0d cycles", c);
      end
      tick();
      cfg_valid = 1'b0;
   endtask

   // Monitor: period windows bounded by cyc_start, cfg_err pulses, overlap.
   initial begin
      bit          have_win;
      logic [31:0] acc_hi, acc_lo;
      int          acc_len;
      logic        acc_ovl;
      win_t        w;
      have_win = 1'b0;
      acc_hi   = '0;
      acc_lo   = '0;
      acc_len  = 0;
      acc_ovl  = 1'b0;
      forever begin
         @(negedge clk);
         if (sw1 && sw2) ovl_cycles++;
         if (rst_n && cfg_err) begin
            total++;
            if (err_q.size() == 0) begin
               bad++;
               $display("FAIL cfg_err: got unexpected pulse expected none");
            end else begin
               void'(err_q.pop_front());
            end
         end
         if (!rst_n || !en) begin
            have_win = 1'b0;
         end else begin
            if (cyc_start) begin
               if (have_win) begin
                  if (win_q.size() == 0) begin
                     total++;
                     bad++;
                     $display("FAIL window: got unexpected period len=%0d expected none", acc_len);
                  end else begin
                     w = win_q.pop_front();
                     check("win_len", acc_len, w.len);
                     check("win_sw1", acc_hi, w.hi);
                     check("win_sw2", acc_lo, w.lo);
                     check("win_overlap", {31'd0, acc_ovl}, 32'd0);
                  end
               end
               have_win = 1'b1;
               acc_hi   = '0;
               acc_lo   = '0;
               acc_len  = 0;
               acc_ovl  = 1'b0;
            end
            if (have_win) begin
               if (acc_len < 32) begin
                  acc_hi[acc_len] = sw1;
                  acc_lo[acc_len] = sw2;
               end
               if (sw1 && sw2) acc_ovl = 1'b1;
               acc_len++;
            end
         end
      end
   end

   // Driver
   initial begin
      int c;
      int low_cnt;

      // Reset state
      repeat (3) tick();
      @(negedge clk);
      check("rst_sw1", sw1, 0);
      check("rst_sw2", sw2, 0);
      check("rst_cyc_start", cyc_start, 0);
      check("rst_cfg_err", cfg_err, 0);
      check("rst_cfg_ready", cfg_ready, 1);
      check("rst_cnt", dut.u_carrier.cnt_q, 0);
      check("rst_period", dut.u_carrier.period_q, 100);
      check("rst_duty", dut.u_carrier.duty_q, 0);
      check("rst_dt", dut.u_carrier.dt_q, 4);
      check("rst_state", 32'(dut.state_q), 32'(ST_OFF));
      tick();
      rst_n = 1'b1;

      // Period 10, duty 5, dt 2: HI 3, dead 2, LO 3, dead 2 per period
      send_cfg(16'd10, 16'd5, 8'd2);
      tick();
      check("idle_copy_period", dut.u_carrier.period_q, 10);
      push_win(32'h038, 32'h301, 10, 4);
      en = 1'b1;
      wait_cs(1);
      wait_cs(3);

      // Mid-period offer at cnt=3: ready low cnt 4..9, duty 3 from next wrap
      tick();
      tick();
      tick();
      push_win(32'h008, 32'h3C1, 10, 2);
      send_cfg(16'd10, 16'd3, 8'd2);
      low_cnt = 0;
      c       = 0;
      do begin
         @(negedge clk);
         c++;
         if (!cyc_start && !cfg_ready) low_cnt++;
      end while (!cyc_start && c < 50);
      check("ready_low_cycles", low_cnt, 6);
      check("ready_at_wrap", cfg_ready, 1);
      wait_cs(2);

      // Duty 0 (all LO), then duty 10 (one DT_HI, then all HI)
      tick();
      en = 1'b0;
      tick();
      send_cfg(16'd10, 16'd0, 8'd2);
      tick();
      push_win(32'h000, 32'h3FF, 10, 3);
      en = 1'b1;
      wait_cs(3);
      tick();
      push_win(32'h3F8, 32'h001, 10, 1);
      push_win(32'h3FF, 32'h000, 10, 1);
      send_cfg(16'd10, 16'd10, 8'd2);
      wait_cs(3);

      // Zero-period offer: rejected, one cfg_err pulse, active unchanged
      tick();
      err_q.push_back(1'b1);
      push_win(32'h3FF, 32'h000, 10, 2);
      cfg_period = 16'd0;
      cfg_duty   = 16'd3;
      cfg_dt     = 8'd1;
      cfg_valid  = 1'b1;
      @(negedge clk);
      check("zero_ready_before", cfg_ready, 1);
      tick();
      cfg_valid = 1'b0;
      @(negedge clk);
      check("zero_err_pulse", cfg_err, 1);
      check("zero_ready_after", cfg_ready, 1);
      check("zero_period_kept", dut.u_carrier.period_q, 10);
      check("zero_duty_kept", dut.u_carrier.duty_q, 10);
      tick();
      @(negedge clk);
      check("zero_err_single", cfg_err, 0);
      wait_cs(2);

      // dt 6 longer than duty 3: DT_HI falls back to LO, sw1 never high
      tick();
      en = 1'b0;
      tick();
      send_cfg(16'd20, 16'd3, 8'd6);
      tick();
      push_win(32'h00000, 32'hFFFF1, 20, 2);
      en = 1'b1;
      wait_cs(3);

      // Reset during HI with a config pending in the shadow
      tick();
      en = 1'b0;
      tick();
      send_cfg(16'd10, 16'd5, 8'd2);
      tick();
      en = 1'b1;
      c  = 0;
      do begin
         @(negedge clk);
         c++;
      end while (!sw1 && c < 50);
      check("hi_reached", sw1, 1);
      tick();
      cfg_period = 16'd40;
      cfg_duty   = 16'd20;
      cfg_dt     = 8'd1;
      cfg_valid  = 1'b1;
      tick();
      cfg_valid = 1'b0;
      rst_n     = 1'b0;
      @(negedge clk);
      check("pre_rst_sw1", sw1, 1);
      check("pre_rst_ready", cfg_ready, 0);
      tick();
      @(negedge clk);
      check("mid_rst_sw1", sw1, 0);
      check("mid_rst_sw2", sw2, 0);
      check("mid_rst_cnt", dut.u_carrier.cnt_q, 0);
      check("mid_rst_period", dut.u_carrier.period_q, 100);
      check("mid_rst_dt", dut.u_carrier.dt_q, 4);
      check("mid_rst_ready", cfg_ready, 1);
      check("mid_rst_state", 32'(dut.state_q), 32'(ST_OFF));
      tick();
      en    = 1'b0;
      rst_n = 1'b1;
      repeat (3) tick();

      check("windows_left", win_q.size(), 0);
      check("err_left", err_q.size(), 0);
      check("overlap_cycles", ovl_cycles, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
